paddle_ctrl: RTL and testbench

Paddle controller that sits directly upstream of the ball engine. It turns raw player push-buttons, or a ball-tracking auto mode for the bottom paddle, into the two paddle centre positions `x_paddle_l` (top paddle) and `x_paddle_r` (bottom paddle). Positions move one pixel per step tick and are clamped so the paddle never leaves the 800-pixel playfield. Outputs are registered and feed the ball engine's hit test directly.

---
 rtl/pong_pkg.sv | 43 ++++
 rtl/debounce.sv | 44 ++++
 rtl/paddle_ctrl.sv | 110 +++++++++++
 tb/tb_paddle_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared playfield constants and helpers for the pong datapath
package pong_pkg;

    // Playfield geometry
    localparam int H             = 800;
    localparam int V             = 600;
    localparam int PADDLE_HALF_W = 60;
    localparam int START_X       = 400;

    // Horizontal position width
    localparam int XW = 11;

    // Ball engine wall rows
    localparam int WALL_TOP    = 30;
    localparam int WALL_BOTTOM = 571;

    // Bits needed to hold a count of 0..n-1 (never less than one bit)
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Apply a signed step to a position and hold it inside [lo, hi]
    function automatic logic [XW-1:0] clamp_step(
        input logic        [XW-1:0] pos,
        input logic signed [XW:0]   dir,
        input int                   lo,
        input int                   hi
    );
        logic signed [XW:0] next;
        logic signed [XW:0] lo_s;
        logic signed [XW:0] hi_s;
        next = $signed({1'b0, pos}) + dir;
        lo_s = (XW+1)'(lo);
        hi_s = (XW+1)'(hi);
        if (next < lo_s) begin
            next = lo_s;
        end else if (next > hi_s) begin
            next = hi_s;
        end
        return next[XW-1:0];
    endfunction

endpackage

// File: rtl/debounce.sv
// rtl/debounce.sv - two-flop synchronizer plus stable-level debouncer for one raw input
module debounce #(
    parameter int CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);
    import pong_pkg::*;

    localparam int CW = cnt_width(CYCLES);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous input into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    // Accept a new level only after it has differed for CYCLES consecutive cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync[1] == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(CYCLES - 1)) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - button/auto-tracking paddle controller with clamped position registers
module paddle_ctrl #(
    parameter int H               = pong_pkg::H,
    parameter int HALF_W          = pong_pkg::PADDLE_HALF_W,
    parameter int START_X         = pong_pkg::START_X,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int STEP_DIV        = 50000,
    parameter int DEADBAND        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      btn_l_left,
    input  logic                      btn_l_right,
    input  logic                      btn_r_left,
    input  logic                      btn_r_right,
    input  logic                      auto_r,
    input  logic [pong_pkg::XW-1:0]   ball_x,
    output logic [pong_pkg::XW-1:0]   x_paddle_l,
    output logic [pong_pkg::XW-1:0]   x_paddle_r
);
    import pong_pkg::*;

    localparam int SW = cnt_width(STEP_DIV);

    logic w_l_left;
    logic w_l_right;
    logic w_r_left;
    logic w_r_right;
    logic w_auto;

    logic [SW-1:0]      r_step_cnt;
    logic               w_tick;
    logic signed [XW:0] w_dir_l;
    logic signed [XW:0] w_dir_r;
    logic signed [XW:0] w_pos_r_s;
    logic signed [XW:0] w_ball_s;
    logic signed [XW:0] w_db;
    logic [XW-1:0]      r_x_l;
    logic [XW-1:0]      r_x_r;

    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_l_left (
        .clk(clk), .rst(rst), .i_raw(btn_l_left),  .o_level(w_l_left)
    );
    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_l_right (
        .clk(clk), .rst(rst), .i_raw(btn_l_right), .o_level(w_l_right)
    );
    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_r_left (
        .clk(clk), .rst(rst), .i_raw(btn_r_left),  .o_level(w_r_left)
    );
    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_r_right (
        .clk(clk), .rst(rst), .i_raw(btn_r_right), .o_level(w_r_right)
    );
    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_auto (
        .clk(clk), .rst(rst), .i_raw(auto_r),      .o_level(w_auto)
    );

    assign w_tick = (r_step_cnt == SW'(STEP_DIV - 1));

    // Free-running step divider; the last count is the tick cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step_cnt <= '0;
        end else if (w_tick) begin
            r_step_cnt <= '0;
        end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
        end
    end

    assign w_pos_r_s = $signed({1'b0, r_x_r});
    assign w_ball_s  = $signed({1'b0, ball_x});
    assign w_db      = (XW+1)'(DEADBAND);

    // Pick each paddle's direction; auto mode overrides the bottom buttons
    always_comb begin
        w_dir_l = '0;
        w_dir_r = '0;
        if (w_l_left && !w_l_right) begin
            w_dir_l = (XW+1)'(-1);
        end else if (w_l_right && !w_l_left) begin
            w_dir_l = (XW+1)'(1);
        end
        if (w_auto) begin
            if (w_ball_s > w_pos_r_s + w_db) begin
                w_dir_r = (XW+1)'(1);
            end else if (w_ball_s < w_pos_r_s - w_db) begin
                w_dir_r = (XW+1)'(-1);
            end
        end else if (w_r_left && !w_r_right) begin
            w_dir_r = (XW+1)'(-1);
        end else if (w_r_right && !w_r_left) begin
            w_dir_r = (XW+1)'(1);
        end
    end

    // Move both paddles one pixel per tick, held inside the playfield
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x_l <= XW'(START_X);
            r_x_r <= XW'(START_X);
        end else if (w_tick) begin
            r_x_l <= clamp_step(r_x_l, w_dir_l, HALF_W, H - HALF_W);
            r_x_r <= clamp_step(r_x_r, w_dir_r, HALF_W, H - HALF_W);
        end
    end

    assign x_paddle_l = r_x_l;
    assign x_paddle_r = r_x_r;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - self-checking bench for paddle_ctrl against a behavioural model
module tb_paddle_ctrl;

    localparam int DEB   = 4;
    localparam int STEP  = 8;
    localparam int PH    = 800;
    localparam int HALF  = 60;
    localparam int STARTX = 400;
    localparam int DBAND = 2;

    logic        clk;
    logic        rst;
    logic [4:0]  raw;
    logic [10:0] ball_x;
    logic [10:0] x_paddle_l;
    logic [10:0] x_paddle_r;

    int checks;
    int errors;

    // Model state: indices 0 l_left, 1 l_right, 2 r_left, 3 r_right, 4 auto
    int m_s0  [5];
    int m_s1  [5];
    int m_lvl [5];
    int m_run [5];
    int m_edges;
    int m_xl;
    int m_xr;

    paddle_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .STEP_DIV(STEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_l_left(raw[0]),
        .btn_l_right(raw[1]),
        .btn_r_left(raw[2]),
        .btn_r_right(raw[3]),
        .auto_r(raw[4]),
        .ball_x(ball_x),
        .x_paddle_l(x_paddle_l),
        .x_paddle_r(x_paddle_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int clampi(input int v);
        if (v < HALF) return HALF;
        if (v > PH - HALF) return PH - HALF;
        return v;
    endfunction

    function automatic int man_dir(input int l, input int r);
        if (l != 0 && r == 0) return -1;
        if (r != 0 && l == 0) return 1;
        return 0;
    endfunction

    // Behavioural model: tick every STEP edges after reset, debounce as run length
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int i = 0; i < 5; i++) begin
                    m_s0[i] = 0; m_s1[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
                end
                m_edges = 0;
                m_xl = STARTX;
                m_xr = STARTX;
            end else begin
                int dl;
                int dr;
                m_edges = m_edges + 1;
                if (m_edges % STEP == 0) begin
                    dl = man_dir(m_lvl[0], m_lvl[1]);
                    if (m_lvl[4] != 0) begin
                        if (int'(ball_x) > m_xr + DBAND) dr = 1;
                        else if (int'(ball_x) < m_xr - DBAND) dr = -1;
                        else dr = 0;
                    end else begin
                        dr = man_dir(m_lvl[2], m_lvl[3]);
                    end
                    m_xl = clampi(m_xl + dl);
                    m_xr = clampi(m_xr + dr);
                end
                for (int i = 0; i < 5; i++) begin
                    if (m_s1[i] != m_lvl[i]) begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == DEB) begin
                            m_lvl[i] = m_s1[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                    m_s1[i] = m_s0[i];
                    m_s0[i] = int'(raw[i]);
                end
            end
        end
    end

    // Every-cycle comparison of both outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            checks = checks + 2;
            if (int'(x_paddle_l) != m_xl) begin
                errors = errors + 1;
                $display("FAIL model_l t=%0t got %0d want %0d", $time, x_paddle_l, m_xl);
            end
            if (int'(x_paddle_r) != m_xr) begin
                errors = errors + 1;
                $display("FAIL model_r t=%0t got %0d want %0d", $time, x_paddle_r, m_xr);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive_slot();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_l(input int val, input int bound);
        bit found;
        found = 0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (int'(x_paddle_l) == val) found = 1;
        end
        checks = checks + 1;
        if (!found) begin
            errors = errors + 1;
            $display("FAIL wait_l_%0d got %0d want %0d", val, x_paddle_l, val);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        raw    = '0;
        ball_x = 11'd400;

        // Reset hold and idle run
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_l", int'(x_paddle_l), 400);
        chk("reset_r", int'(x_paddle_r), 400);
        drive_slot();
        rst = 1'b1;
        repeat (100 * STEP) @(negedge clk);
        chk("idle_l", int'(x_paddle_l), 400);
        chk("idle_r", int'(x_paddle_r), 400);

        // Manual move right, saturate high, then saturate low
        drive_slot();
        raw[1] = 1'b1;
        wait_l(401, 40);
        repeat (99 * STEP) @(negedge clk);
        chk("right_100", int'(x_paddle_l), 500);
        repeat (300 * STEP) @(negedge clk);
        chk("sat_hi", int'(x_paddle_l), 740);
        drive_slot();
        raw[1] = 1'b0;
        raw[0] = 1'b1;
        repeat (1000 * STEP) @(negedge clk);
        chk("sat_lo", int'(x_paddle_l), 60);

        // Glitch rejection on the bottom buttons
        drive_slot();
        raw[0] = 1'b0;
        for (int p = 0; p < 40; p++) begin
            drive_slot();
            raw[3] = 1'b1;
            repeat (3) drive_slot();
            raw[3] = 1'b0;
            repeat (6) drive_slot();
        end
        @(negedge clk);
        chk("glitch_r", int'(x_paddle_r), 400);
        chk("glitch_l", int'(x_paddle_l), 60);
        drive_slot();
        raw[2] = 1'b1;
        raw[3] = 1'b1;
        repeat (100) @(negedge clk);
        chk("both_r", int'(x_paddle_r), 400);

        // Auto tracking overrides the held right button
        drive_slot();
        raw[2] = 1'b0;
        raw[4] = 1'b1;
        ball_x = 11'd100;
        repeat (2700) @(negedge clk);
        chk("auto_102", int'(x_paddle_r), 102);
        drive_slot();
        ball_x = 11'd103;
        repeat (200) @(negedge clk);
        chk("auto_103", int'(x_paddle_r), 102);
        drive_slot();
        ball_x = 11'd101;
        repeat (200) @(negedge clk);
        chk("auto_101", int'(x_paddle_r), 102);
        drive_slot();
        ball_x = 11'd110;
        repeat (200) @(negedge clk);
        chk("auto_110", int'(x_paddle_r), 108);
        drive_slot();
        raw[4] = 1'b0;
        repeat (80) @(negedge clk);
        drive_slot();
        raw[3] = 1'b0;

        // Reset mid-motion at 650, then re-debounce before moving again
        drive_slot();
        raw[1] = 1'b1;
        wait_l(650, 6000);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_l", int'(x_paddle_l), 400);
        chk("async_rst_r", int'(x_paddle_r), 400);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (STEP - 1) @(posedge clk);
        @(negedge clk);
        chk("post_rst_hold", int'(x_paddle_l), 400);
        @(negedge clk);
        chk("post_rst_move", int'(x_paddle_l), 401);
        repeat (4 * STEP) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
